// File: rtl/apple1_kbd_pkg.sv
// rtl/apple1_kbd_pkg.sv - shared states, character constants and paste filter for the Apple-1 paste buffer
package apple1_kbd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FETCH,
    ST_FILTER,
    ST_PRESENT,
    ST_DELAY
  } state_t;

  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_LF       = 8'h0A;
  localparam logic [7:0] KBD_CR         = 8'h8D;
  localparam int         KBD_STROBE_BIT = 7;

  // Maps one file byte to an Apple-1 key code; result is {emit, code}.
  // A LF directly after an emitted CR is swallowed so CRLF files give one CR.
  function automatic logic [8:0] filter_char(input logic [7:0] b, input logic last_cr);
    logic [7:0] c;
    logic       emit;
    c    = {1'b1, b[6:0]};
    emit = 1'b1;
    if (b == 8'h00 || b[7]) begin
      emit = 1'b0;
    end else if (b == ASCII_LF) begin
      c    = KBD_CR;
      emit = !last_cr;
    end else if (b == ASCII_CR) begin
      c = KBD_CR;
    end else if (b >= 8'h61 && b <= 8'h7A) begin
      c = {1'b1, b[6:0] - 7'h20};
    end
    return {emit, c};
  endfunction

endpackage

// File: rtl/text_buf_ram.sv
// rtl/text_buf_ram.sv - simple dual-port byte RAM holding the pasted text
module text_buf_ram #(
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk25,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [2**ADDR_W];

  // Write port from the download stream.
  always_ff @(posedge clk25) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port: data appears one cycle after the address.
  always_ff @(posedge clk25) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/kbd_paste_buffer.sv
// rtl/kbd_paste_buffer.sv - captures a downloaded text file and replays it through KBD/KBDCR
module kbd_paste_buffer
  import apple1_kbd_pkg::*;
#(
  parameter int unsigned ADDR_W     = 13,
  parameter int unsigned CHAR_DELAY = 2500,
  parameter int unsigned CR_DELAY   = 2500000
) (
  input  logic        clk25,
  input  logic        rst,
  input  logic        cpu_clken,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [12:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        cs,
  input  logic        rd,
  input  logic        address,
  output logic [7:0]  dout,
  output logic        data_ready,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned CNT_MAX = (CR_DELAY > CHAR_DELAY) ? CR_DELAY : CHAR_DELAY;
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W:0]   wr_len;
  logic [CNT_W-1:0]  delay_cnt;
  logic [7:0]        char_q;
  logic [7:0]        ram_q;
  logic [7:0]        dout_nxt;
  logic [8:0]        filt;
  logic              last_cr;
  logic              in_range;
  logic              wr_ok;
  logic              abort;
  logic              kbd_read;

  assign in_range = (32'(ioctl_addr) < DEPTH);
  assign wr_ok    = (state == ST_LOAD) && ioctl_download && ioctl_wr && in_range;
  assign wr_len   = {1'b0, ioctl_addr[ADDR_W-1:0]} + PTR_ONE;
  assign abort    = ioctl_download && (state != ST_LOAD);
  assign kbd_read = (state == ST_PRESENT) && cs && rd && cpu_clken && !address;
  assign filt     = filter_char(ram_q, last_cr);

  text_buf_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk25 (clk25),
    .we    (wr_ok),
    .waddr (ioctl_addr[ADDR_W-1:0]),
    .wdata (ioctl_dout),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (ram_q)
  );

  // State register.
  always_ff @(posedge clk25) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state, status outputs and register read mux; a new download always wins.
  always_comb begin
    state_nxt  = state;
    data_ready = (state == ST_PRESENT);
    busy       = (state != ST_IDLE);
    dout_nxt   = 8'h00;
    if (address) begin
      dout_nxt[KBD_STROBE_BIT] = data_ready;
    end else begin
      dout_nxt                 = char_q;
      dout_nxt[KBD_STROBE_BIT] = 1'b1;
    end
    if (abort) begin
      state_nxt = ST_LOAD;
    end else begin
      case (state)
        ST_LOAD:    if (!ioctl_download) state_nxt = (len != '0) ? ST_FETCH : ST_IDLE;
        ST_FETCH:   state_nxt = (rd_ptr == len) ? ST_IDLE : ST_FILTER;
        ST_FILTER:  state_nxt = filt[8] ? ST_PRESENT : ST_FETCH;
        ST_PRESENT: if (kbd_read) state_nxt = ST_DELAY;
        ST_DELAY:   if (delay_cnt <= CNT_W'(1)) state_nxt = ST_FETCH;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  // Datapath: length tracking, read pointer, latched character and pacing counter.
  always_ff @(posedge clk25) begin
    if (rst) begin
      dout      <= 8'h00;
      overflow  <= 1'b0;
      len       <= '0;
      rd_ptr    <= '0;
      delay_cnt <= '0;
      char_q    <= 8'h00;
      last_cr   <= 1'b0;
    end else begin
      dout <= dout_nxt;
      if (abort) begin
        len      <= '0;
        overflow <= 1'b0;
      end else begin
        case (state)
          ST_LOAD: begin
            if (ioctl_download && ioctl_wr) begin
              if (!in_range)          overflow <= 1'b1;
              else if (wr_len > len)  len      <= wr_len;
            end
            if (!ioctl_download) begin
              rd_ptr  <= '0;
              last_cr <= 1'b0;
            end
          end
          ST_FILTER: begin
            rd_ptr <= rd_ptr + PTR_ONE;
            if (filt[8]) begin
              char_q  <= filt[7:0];
              last_cr <= (filt[7:0] == KBD_CR);
            end
          end
          ST_PRESENT: begin
            if (kbd_read) delay_cnt <= (char_q == KBD_CR) ? CNT_W'(CR_DELAY) : CNT_W'(CHAR_DELAY);
          end
          ST_DELAY: begin
            if (delay_cnt != '0) delay_cnt <= delay_cnt - CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kbd_paste_buffer.sv
// tb/tb_kbd_paste_buffer.sv - self-checking bench for kbd_paste_buffer
module tb_kbd_paste_buffer;

  localparam int ADDR_W     = 4;
  localparam int CHAR_DELAY = 20;
  localparam int CR_DELAY   = 60;

  logic        clk25 = 1'b0;
  logic        rst;
  logic        cpu_clken;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [12:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        cs;
  logic        rd;
  logic        address;
  logic [7:0]  dout;
  logic        data_ready;
  logic        busy;
  logic        overflow;

  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] sb_q[$];

  typedef struct {
    string       name;
    logic [63:0] in_bytes;
    int          n_in;
    logic [63:0] exp_bytes;
    int          n_exp;
  } vec_t;

  vec_t vecs[5];

  kbd_paste_buffer #(
    .ADDR_W     (ADDR_W),
    .CHAR_DELAY (CHAR_DELAY),
    .CR_DELAY   (CR_DELAY)
  ) dut (
    .clk25          (clk25),
    .rst            (rst),
    .cpu_clken      (cpu_clken),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .cs             (cs),
    .rd             (rd),
    .address        (address),
    .dout           (dout),
    .data_ready     (data_ready),
    .busy           (busy),
    .overflow       (overflow)
  );

  always #20 clk25 = ~clk25;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk25);
    #1;
  endtask

  task automatic dl_begin();
    ioctl_download = 1'b1;
    step();
  endtask

  task automatic dl_byte(input int a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = 13'(a);
    ioctl_dout = d;
    step();
    ioctl_wr = 1'b0;
    step();
  endtask

  task automatic dl_end();
    ioctl_download = 1'b0;
    step();
  endtask

  task automatic kbd_read(output logic [7:0] v);
    cs = 1'b1; rd = 1'b1; address = 1'b0;
    step();
    v  = dout;
    cs = 1'b0; rd = 1'b0; address = 1'b1;
  endtask

  task automatic wait_ready(input int budget, output int low);
    low = 0;
    while (!data_ready && low < budget) begin
      low++;
      step();
    end
  endtask

  task automatic wait_idle(input string name);
    int b;
    b = 0;
    while (busy && b < 1000) begin
      b++;
      step();
    end
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  // Reads every character the DUT offers and compares it with the scoreboard.
  task automatic play_out(input string name);
    int budget;
    logic [7:0] v;
    logic [7:0] e;
    budget = 4000;
    address = 1'b1;
    step();
    while (busy && budget > 0) begin
      if (dout == 8'h80) begin
        kbd_read(v);
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL %s_extra: got 0x%0h required no character", name, v);
        end else begin
          e = sb_q.pop_front();
          check({name, "_char"}, 32'(v), 32'(e));
        end
      end
      step();
      budget--;
    end
    check({name, "_done"}, 32'(busy), 32'd0);
    check({name, "_missing"}, 32'(sb_q.size()), 32'd0);
    check({name, "_ready_low"}, 32'(data_ready), 32'd0);
    sb_q.delete();
  endtask

  task automatic run_vec(input vec_t v);
    dl_begin();
    for (int k = 0; k < v.n_in; k++) dl_byte(k, v.in_bytes[63-8*k -: 8]);
    for (int k = 0; k < v.n_exp; k++) sb_q.push_back(v.exp_bytes[63-8*k -: 8]);
    dl_end();
    play_out(v.name);
  endtask

  task automatic load_file(input logic [63:0] bytes, input int n);
    dl_begin();
    for (int k = 0; k < n; k++) dl_byte(k, bytes[63-8*k -: 8]);
    dl_end();
  endtask

  initial begin
    int         low;
    logic [7:0] v;
    vec_t       nv;

    vecs[0] = '{"ab_lf",       64'h61620A0000000000, 3, 64'hC1C28D0000000000, 3};
    vecs[1] = '{"crlf_filter", 64'h410D0A00C5420000, 6, 64'hC18DC20000000000, 3};
    vecs[2] = '{"case_edges",  64'h607A7B1F7F200000, 6, 64'hE0DAFB9FFFA00000, 6};
    vecs[3] = '{"lf_first",    64'h0A0A410000000000, 3, 64'h8DC1000000000000, 2};
    vecs[4] = '{"empty",       64'h0,                0, 64'h0,                0};

    rst = 1'b1; cpu_clken = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; cs = 1'b0; rd = 1'b0; address = 1'b0;
    step(); step();
    check("reset_dout", 32'(dout), 32'h00);
    check("reset_ready", 32'(data_ready), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // KBDCR polling and clken-gated reads leave the pending key alone; pacing after a key.
    load_file(64'h4142000000000000, 2);
    wait_ready(200, low);
    check("hs_first_ready", 32'(data_ready), 32'd1);
    cs = 1'b1; rd = 1'b1; address = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("hs_kbdcr_poll", 32'(dout), 32'h80);
    end
    cpu_clken = 1'b0; address = 1'b0;
    step();
    cs = 1'b0; rd = 1'b0; cpu_clken = 1'b1;
    check("hs_no_clken_ready", 32'(data_ready), 32'd1);
    check("hs_kbd_peek", 32'(dout), 32'hC1);
    kbd_read(v);
    check("hs_read_a", 32'(v), 32'hC1);
    wait_ready(200, low);
    check("hs_char_delay", 32'(low), 32'(CHAR_DELAY + 2));
    check("hs_kbdcr_delay", 32'(dout), 32'h00);
    step();
    check("hs_kbdcr_ready", 32'(dout), 32'h80);
    kbd_read(v);
    check("hs_read_b", 32'(v), 32'hC2);
    wait_idle("hs");

    // CR pacing: the long line delay follows a CR.
    load_file(64'h410D420000000000, 3);
    wait_ready(200, low);
    kbd_read(v);
    check("cr_read_a", 32'(v), 32'hC1);
    wait_ready(200, low);
    kbd_read(v);
    check("cr_read_cr", 32'(v), 32'h8D);
    address = 1'b0;
    step();
    check("cr_delay_kbd", 32'(dout), 32'h8D);
    address = 1'b1;
    wait_ready(500, low);
    check("cr_delay_len", 32'(low + 1), 32'(CR_DELAY + 2));
    kbd_read(v);
    check("cr_read_b", 32'(v), 32'hC2);
    wait_idle("cr");

    // Reset while a key is pending.
    load_file(64'h4142000000000000, 2);
    wait_ready(200, low);
    kbd_read(v);
    wait_ready(200, low);
    check("rst_b_pending", 32'(data_ready), 32'd1);
    rst = 1'b1;
    step();
    check("rst_ready", 32'(data_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0; address = 1'b1;
    step();
    check("rst_kbdcr", 32'(dout), 32'h00);

    // New download during the pacing delay restarts from the new file.
    load_file(64'h4142000000000000, 2);
    wait_ready(200, low);
    kbd_read(v);
    nv = '{"redl", 64'h7879000000000000, 2, 64'hD8D9000000000000, 2};
    run_vec(nv);

    // Full buffer plus one out-of-range byte.
    dl_begin();
    for (int k = 0; k < 16; k++) begin
      dl_byte(k, 8'(8'h61 + k));
      sb_q.push_back(8'(8'hC1 + k));
    end
    dl_byte(16, 8'h5A);
    check("ovf_set", 32'(overflow), 32'd1);
    dl_end();
    play_out("ovf");
    check("ovf_sticky", 32'(overflow), 32'd1);
    run_vec(vecs[0]);
    check("ovf_cleared", 32'(overflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/kbd_paste_buffer.md
Name: kbd_paste_buffer

Overview:
- Text-paste front end for the Apple-1 keyboard register pair (KBD 0xD010, KBDCR 0xD011).
- Captures a text file streamed over the ioctl download port into a local buffer.
- After the download ends, replays the buffer one character at a time to the CPU as if typed.
- Applies Apple-1 character normalisation and pacing, so WozMon and BASIC can consume pasted programs without dropping keys.

Parameters:
- ADDR_W, 13, buffer address width; depth = 2**ADDR_W bytes.
- CHAR_DELAY, 2500, clk25 cycles between the CPU reading a character and the next one becoming ready (100 us).
- CR_DELAY, 2500000, clk25 cycles after a CR (0x8D) is read before the next character becomes ready (100 ms, line-processing time).

Ports:
- clk25  in  1  master clock, 25 MHz.
- rst  in  1  synchronous reset, active high.
- cpu_clken  in  1  CPU clock enable; register reads take effect only when this is high.
- ioctl_download  in  1  high while a file download is active.
- ioctl_wr  in  1  byte write strobe, one cycle per byte.
- ioctl_addr  in  13  byte offset in the file.
- ioctl_dout  in  8  file byte.
- cs  in  1  register select (rx_cs gated by ps2_select).
- rd  in  1  CPU read qualifier (cs & ~we).
- address  in  1  ab[0]: 0 selects KBD, 1 selects KBDCR.
- dout  out  8  register read data.
- data_ready  out  1  a pasted character is pending; the address decoder uses it to steer the data mux.
- busy  out  1  high in any state other than IDLE.
- overflow  out  1  sticky; set when a download byte falls outside the buffer.

Behaviour:
- Synchronous reset only, active high; all state changes on posedge clk25.
- Reset values: state=IDLE, dout=0x00, data_ready=0, busy=0, overflow=0, len=0, rd_ptr=0, delay counter=0.
- Reset mid-operation aborts immediately; data_ready is low on the cycle after rst is sampled.
- States: IDLE, LOAD, FETCH, FILTER, PRESENT, DELAY.
- IDLE -> LOAD when ioctl_download=1; on entry, len=0 and overflow is cleared.
- LOAD:
  - On each ioctl_wr with ioctl_addr < 2**ADDR_W, write the byte at that address and set len = max(len, ioctl_addr+1).
  - An address at or beyond the buffer is dropped and sets overflow.
  - On the ioctl_download falling edge: rd_ptr=0; go to FETCH if len != 0, otherwise go to IDLE.
- FETCH:
  - Present rd_ptr to the buffer RAM; read latency is 1 cycle.
  - If rd_ptr == len, go to IDLE instead.
- FILTER: examine byte b = ram_q, then increment rd_ptr.
  - b==0x0A: if the previously emitted character was CR, drop it; otherwise emit CR.
  - b==0x0D: emit CR.
  - 0x61..0x7A: subtract 0x20 (convert to uppercase).
  - 0x00 or b >= 0x80: drop.
  - 0x01..0x1F other than CR/LF: emit unchanged.
  - Emitted character = {1'b1, b[6:0]}, latched into char_q. Go to PRESENT.
  - A dropped byte returns to FETCH.
- PRESENT:
  - data_ready=1.
  - Read of address 0: dout={1'b1, char_q[6:0]}.
  - Read of address 1: dout={data_ready, 7'b0}.
  - A read of address 0 with cs & rd & cpu_clken clears data_ready on the next cycle, loads the delay counter (CR_DELAY if char_q==0x8D, else CHAR_DELAY), and moves to DELAY.
  - Reads of address 1 have no side effect.
- DELAY:
  - data_ready=0.
  - Address-1 reads return 0x00; address-0 reads return the last char_q.
  - Count down to 0, then go to FETCH.
- dout is updated every cycle from address regardless of cs; the external mux qualifies it.
- ioctl_download rising in any state other than LOAD aborts playback: data_ready drops next cycle, then LOAD.
- Simultaneous ioctl_wr and the KBD-read strobe: the download abort wins and the read is ignored.
- rd_ptr and len are ADDR_W+1 bits wide, so a full buffer (len = 2**ADDR_W) terminates correctly with no wrap-around.
- Throughput: FETCH -> FILTER -> PRESENT takes 2 cycles per emitted character.

Decomposition:
- Package apple1_kbd_pkg holds:
  - the state enum;
  - constants ASCII_CR=0x0D, ASCII_LF=0x0A, KBD_CR=0x8D, KBD_STROBE_BIT=7.
- Sub-module text_buf_ram: a simple dual-port RAM (write port driven by ioctl, registered read port), 2**ADDR_W x 8, one-cycle read latency.
- The FSM, filter and pacing counter stay in kbd_paste_buffer.

Test Plan:
- Download "ab\n" (0x61,0x62,0x0A), drop ioctl_download -> three KBD reads return 0xC1, 0xC2, 0x8D; then busy=0, data_ready=0.
- Handshake: pending 'A' -> KBDCR reads 0x80 repeatedly with no effect; after a KBD read, KBDCR reads 0x00 for exactly CHAR_DELAY cycles (+2 fetch), then 0x80.
- CR pacing: "A\rB" -> after 0x8D is read, data_ready stays low for CR_DELAY cycles before 0xC2 appears.
- CRLF and filtering: 0x41,0x0D,0x0A,0x00,0xC5,0x42 -> emitted sequence is exactly 0xC1, 0x8D, 0xC2.
- Abort: rst asserted while 'B' is pending -> data_ready=0 next cycle, busy=0, KBDCR=0x00. A new download during DELAY -> playback restarts from the new file's first byte.
- Bounds: empty download (no ioctl_wr) -> returns to IDLE with data_ready never set. With ADDR_W=4, a write at ioctl_addr=16 -> overflow=1 and the first 16 bytes replay intact.
